// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle ADD/SUB/MUL/DIV controller around one shared W+1-bit adder/subtractor
// Shift-and-add multiply and restoring divide iterate once per EXEC cycle.

module alu_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  logic [N-1:0] b_eff;
  logic         c_eff;

  // Subtract as a + ~b + ~borrow_in; cout_o=1 then means "no borrow".
  assign b_eff = sub_i ? ~b_i : b_i;
  assign c_eff = sub_i ^ cin_i;
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{N{1'b0}}, c_eff};
endmodule

module alu_sequencer #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           cin,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           carry,
  output logic           overflow,
  output logic           div_zero
);
  localparam int CW = $clog2(W) + 1;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic             cin_q, cin_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic [W:0]       add_a, add_b, add_sum;
  logic             add_sub, add_cin, add_cout;
  logic [W-1:0]     mul_acc_nxt, mul_lo_nxt;
  logic [W-1:0]     div_acc_nxt, div_lo_nxt;
  logic             div_borrow, last_iter, y_zero;

  always_comb begin
    add_a   = {1'b0, x_q};
    add_b   = {1'b0, y_q};
    add_sub = 1'b0;
    add_cin = 1'b0;
    case (op_q)
      OP_ADD: add_cin = cin_q;
      OP_SUB: begin
        add_sub = 1'b1;
        add_cin = cin_q;
      end
      OP_MUL: begin
        add_a = {1'b0, acc_q};
        add_b = lo_q[0] ? {1'b0, x_q} : '0;
      end
      default: begin
        // Remainder shifted left with the next dividend bit, minus divisor.
        add_a   = {acc_q, lo_q[W-1]};
        add_sub = 1'b1;
      end
    endcase
  end

  alu_addsub #(.N(W + 1)) u_addsub (
    .a_i    (add_a),
    .b_i    (add_b),
    .sub_i  (add_sub),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign mul_acc_nxt = add_sum[W:1];
  assign mul_lo_nxt  = {add_sum[0], lo_q[W-1:1]};
  assign div_borrow  = ~add_cout;
  assign div_acc_nxt = div_borrow ? add_a[W-1:0] : add_sum[W-1:0];
  assign div_lo_nxt  = {lo_q[W-2:0], ~div_borrow};
  assign last_iter   = (cnt_q == CW'(W - 1));
  assign y_zero      = (y_q == '0);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    cin_d    = cin_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EXEC;
          op_d    = op;
          x_d     = x;
          y_d     = y;
          cin_d   = cin;
          acc_d   = '0;
          lo_d    = (op == OP_MUL) ? y : x;
          cnt_d   = '0;
          dz_d    = 1'b0;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD: begin
            state_d  = S_DONE;
            result_d = {{W{1'b0}}, add_sum[W-1:0]};
            carry_d  = add_sum[W];
            ovf_d    = (x_q[W-1] == y_q[W-1]) && (add_sum[W-1] != x_q[W-1]);
          end
          OP_SUB: begin
            state_d  = S_DONE;
            result_d = {{W{1'b0}}, add_sum[W-1:0]};
            carry_d  = ~add_cout;
            ovf_d    = (x_q[W-1] != y_q[W-1]) && (add_sum[W-1] != x_q[W-1]);
          end
          OP_MUL: begin
            acc_d = mul_acc_nxt;
            lo_d  = mul_lo_nxt;
            cnt_d = cnt_q + 1'b1;
            if (last_iter) begin
              state_d  = S_DONE;
              result_d = {mul_acc_nxt, mul_lo_nxt};
              carry_d  = 1'b0;
              ovf_d    = |mul_acc_nxt;
            end
          end
          default: begin
            if (y_zero) begin
              state_d  = S_DONE;
              result_d = {x_q, {W{1'b1}}};
              carry_d  = 1'b0;
              ovf_d    = 1'b0;
              dz_d     = 1'b1;
            end else begin
              acc_d = div_acc_nxt;
              lo_d  = div_lo_nxt;
              cnt_d = cnt_q + 1'b1;
              if (last_iter) begin
                state_d  = S_DONE;
                result_d = {div_acc_nxt, div_lo_nxt};
                carry_d  = 1'b0;
                ovf_d    = 1'b0;
              end
            end
          end
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cin_q    <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cin_q    <= cin_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign div_zero = dz_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer at W=8

module tb_alu_sequencer;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        overflow;
  logic        div_zero;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  logic prev_done = 1'b0;

  alu_sequencer #(.W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .x        (x),
    .y        (y),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                                 input logic ci);
    exp_t e;
    int s, sa, sb, sr;
    sa = a[7] ? int'(a) - 256 : int'(a);
    sb = b[7] ? int'(b) - 256 : int'(b);
    e.c = 1'b0; e.v = 1'b0; e.z = 1'b0; e.lat = 9; e.acc = 0; e.name = "";
    case (o)
      2'b00: begin
        s = int'(a) + int'(b) + int'(ci);
        sr = sa + sb + int'(ci);
        e.res = 16'(s & 255); e.c = (s > 255); e.v = (sr > 127) || (sr < -128); e.lat = 2;
      end
      2'b01: begin
        s = int'(a) - int'(b) - int'(ci);
        sr = sa - sb - int'(ci);
        e.res = 16'(s & 255); e.c = (s < 0); e.v = (sr > 127) || (sr < -128); e.lat = 2;
      end
      2'b10: begin
        s = int'(a) * int'(b);
        e.res = 16'(s); e.v = (s > 255);
      end
      default: begin
        if (b == 8'd0) begin
          e.res = {a, 8'hFF}; e.z = 1'b1; e.lat = 2;
        end else begin
          e.res = {8'(a % b), 8'(a / b)};
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      check("done_pulse_width", 32'(prev_done), 32'd0);
      check("busy_with_done", 32'(busy), 32'd1);
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, ".result"}, 32'(result), 32'(mon_e.res));
        check({mon_e.name, ".carry"}, 32'(carry), 32'(mon_e.c));
        check({mon_e.name, ".overflow"}, 32'(overflow), 32'(mon_e.v));
        check({mon_e.name, ".div_zero"}, 32'(div_zero), 32'(mon_e.z));
        check({mon_e.name, ".latency"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
      end
    end
    prev_done = done;
  end

  task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input string nm);
    exp_t e;
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    start = 1'b1; op = o; x = a; y = b; cin = ci;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom); x = 8'($urandom); y = 8'($urandom); cin = 1'($urandom);
    e = model(o, a, b, ci);
    e.name = nm;
    e.acc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 40) begin
      @(negedge clk);
      #2;
      k++;
    end
    check({nm, ".drain"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic run(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input string nm);
    issue(o, a, b, ci, nm);
    wait_done(nm);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; x = 8'd0; y = 8'd0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({busy, done, result, carry, overflow, div_zero}), 32'd0);
    rst_n = 1'b1;

    run(2'b00, 8'd7, 8'd4, 1'b0, "add_7_4");
    run(2'b00, 8'd127, 8'd1, 1'b0, "add_127_1");
    run(2'b00, 8'd255, 8'd1, 1'b0, "add_255_1");
    run(2'b00, 8'd200, 8'd100, 1'b1, "add_cin");
    run(2'b01, 8'd7, 8'd4, 1'b0, "sub_7_4");
    run(2'b01, 8'd4, 8'd7, 1'b0, "sub_4_7");
    run(2'b01, 8'h80, 8'd1, 1'b0, "sub_80_1");
    run(2'b01, 8'd5, 8'd5, 1'b1, "sub_borrow_in");
    run(2'b10, 8'd200, 8'd3, 1'b0, "mul_200_3");
    run(2'b10, 8'd255, 8'd255, 1'b0, "mul_255_255");
    run(2'b10, 8'd0, 8'd99, 1'b0, "mul_0_99");
    run(2'b11, 8'd100, 8'd7, 1'b0, "div_100_7");
    run(2'b11, 8'd5, 8'd9, 1'b0, "div_5_9");
    run(2'b11, 8'd42, 8'd0, 1'b0, "div_42_0");
    run(2'b11, 8'd255, 8'd1, 1'b0, "div_255_1");
    run(2'b01, 8'd1, 8'd1, 1'b0, "sub_clears_dz");

    for (int i = 0; i < 12; i++) begin
      run(2'($urandom), 8'($urandom), 8'($urandom_range(0, 255)), 1'($urandom), "rand");
    end

    // start during EXEC and during DONE must both be dropped
    issue(2'b10, 8'd13, 8'd11, 1'b0, "hs_mul");
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b00; x = 8'd7; y = 8'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      if (!done) check("hs_busy_exec", 32'(busy), 32'd1);
      k++;
    end
    check("hs_done_seen", 32'(done), 32'd1);
    start = 1'b1; op = 2'b00;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("hs_idle_after_done", 32'({busy, done}), 32'd0);
    repeat (4) @(negedge clk);
    check("hs_no_accept", 32'(busy), 32'd0);
    check("hs_queue_empty", 32'(sb_q.size()), 32'd0);

    // reset in the middle of a multiply
    issue(2'b10, 8'd200, 8'd3, 1'b0, "rst_mul");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({busy, done, result, carry, overflow, div_zero}), 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    check("rst_hold_outputs", 32'({busy, done, result, carry, overflow, div_zero}), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_no_done", 32'({busy, done}), 32'd0);
    run(2'b00, 8'd7, 8'd4, 1'b0, "post_rst_add");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
